mux_4to1_serializer: RTL and testbench

- Upstream driver and checker for the 4:1 mux (d[3:0], select[1:0] -> y).
- Accepts a 4-bit word over a valid/ready handshake and presents it on d. It then steps select through all four positions, holding each for HOLD cycles.
- At the end of each hold it samples the mux output y, emits it as a serial bit stream, and flags any mismatch against the expected bit d[select].

---
 rtl/mux_4to1_serializer.sv | 104 ++++++++++
 tb/tb_mux_4to1_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_serializer.sv
// Drives a 4:1 mux with a latched word, steps select through all inputs,
// samples the mux output into a serial stream and flags any mismatch.
module mux_4to1_serializer #(
    parameter int unsigned HOLD      = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] d,
    output logic [1:0] select,
    input  logic       y,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [1:0] FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    logic [1:0] bit_cnt;
    logic       sample_now;
    logic       mismatch;

    always_comb begin
        sample_now = (state == SHIFT) && (hold_cnt == HOLD_LAST);
        mismatch   = sample_now && (y != d[select]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            d         <= '0;
            select    <= FIRST_SEL;
            hold_cnt  <= '0;
            bit_cnt   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;

            // A fresh mismatch takes priority over a simultaneous clear.
            if (mismatch) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        d        <= in_data;
                        select   <= FIRST_SEL;
                        hold_cnt <= '0;
                        bit_cnt  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sample_now) begin
                        ser_bit   <= y;
                        ser_valid <= 1'b1;
                        ser_last  <= (bit_cnt == 2'd3);
                        hold_cnt  <= '0;
                        if (bit_cnt == 2'd3) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            select   <= FIRST_SEL;
                        end else begin
                            bit_cnt <= bit_cnt + 2'd1;
                            select  <= MSB_FIRST ? (select - 2'd1) : (select + 2'd1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4to1_serializer.sv
// Bench for mux_4to1_serializer: two instances (HOLD=1 LSB-first, HOLD=3 MSB-first),
// scoreboard of expected serial bits with exact pulse timing, plus directed checks.
module tb_mux_4to1_serializer;

    localparam int unsigned H0 = 1;
    localparam int unsigned H1 = 3;

    typedef struct {
        logic        b;
        logic        last;
        int unsigned at;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [1:0][3:0] in_data;
    logic [1:0]      in_valid;
    logic [1:0]      err_clr;
    logic [1:0]      fault;
    wire  [1:0]      in_ready;
    wire  [1:0][3:0] d;
    wire  [1:0][1:0] sel;
    wire  [1:0]      y;
    wire  [1:0]      ser_bit;
    wire  [1:0]      ser_valid;
    wire  [1:0]      ser_last;
    wire  [1:0]      busy;
    wire  [1:0]      err;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned pulses [2];
    exp_t        sb [2][$];

    // Behavioural mux; a fault forces its output low.
    assign y[0] = fault[0] ? 1'b0 : d[0][sel[0]];
    assign y[1] = fault[1] ? 1'b0 : d[1][sel[1]];

    mux_4to1_serializer #(.HOLD(H0), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .d(d[0]), .select(sel[0]), .y(y[0]),
        .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .ser_last(ser_last[0]),
        .busy(busy[0]), .err(err[0]), .err_clr(err_clr[0])
    );

    mux_4to1_serializer #(.HOLD(H1), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .d(d[1]), .select(sel[1]), .y(y[1]),
        .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .ser_last(ser_last[1]),
        .busy(busy[1]), .err(err[1]), .err_clr(err_clr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp_v);
        end
    endtask

    function automatic int unsigned hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    // Monitor: runs at the falling edge, after edge number cyc.
    task automatic monitor(input int i);
        exp_t e;
        if (ser_valid[i]) begin
            pulses[i]++;
            if (sb[i].size() == 0) begin
                chk($sformatf("unexpected_pulse%0d", i), 1, 0);
            end else begin
                e = sb[i].pop_front();
                chk($sformatf("pulse_time%0d", i), cyc, e.at);
                chk($sformatf("ser_bit%0d", i), ser_bit[i], e.b);
                chk($sformatf("ser_last%0d", i), ser_last[i], e.last);
            end
        end else begin
            if (ser_last[i]) chk($sformatf("last_without_valid%0d", i), 1, 0);
            if (sb[i].size() != 0 && sb[i][0].at <= cyc) begin
                chk($sformatf("missing_pulse%0d", i), cyc, sb[i][0].at);
                void'(sb[i].pop_front());
            end
        end
        if (!rst_n) begin
            sb[i].delete();
        end else if (in_valid[i] && in_ready[i]) begin
            // Transfer happens at the next edge; bit k is sampled HOLD*(k+1) edges later.
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = msb_of(i) ? 3 - k : k;
                e.b    = fault[i] ? 1'b0 : in_data[i][idx];
                e.last = (k == 3);
                e.at   = cyc + 1 + (k + 1) * hold_of(i);
                sb[i].push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge at which the word was taken.
    task automatic send_word(input int i, input logic [3:0] w);
        int n;
        in_data[i]  = w;
        in_valid[i] = 1'b1;
        n = 0;
        while (!in_ready[i] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk($sformatf("ready_timeout%0d", i), 0, 1);
        tick();
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (!in_ready[i] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk($sformatf("idle_timeout%0d", i), 0, 1);
    endtask

    task automatic rand_driver(input int i, input int words);
        for (int n = 0; n < words; n++) begin
            int gap;
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) begin
                in_data[i] = 4'($urandom_range(15));
                tick();
            end
            send_word(i, 4'($urandom_range(15)));
            in_data[i] = 4'($urandom_range(15));
        end
    endtask

    initial begin
        int unsigned p;
        int          n;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        err_clr   = '0;
        fault     = '0;
        pulses[0] = 0;
        pulses[1] = 0;

        // Reset values
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_d%0d", i), d[i], 0);
            chk($sformatf("rst_sel%0d", i), sel[i], (i == 0) ? 0 : 3);
            chk($sformatf("rst_ready%0d", i), in_ready[i], 0);
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
            chk($sformatf("rst_err%0d", i), err[i], 0);
            chk($sformatf("rst_valid%0d", i), ser_valid[i], 0);
            chk($sformatf("rst_bit%0d", i), ser_bit[i], 0);
        end
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst0", in_ready[0], 1);
        chk("ready_after_rst1", in_ready[1], 1);

        // HOLD=1, LSB-first, 1011
        send_word(0, 4'b1011);
        chk("a_d", d[0], 4'b1011);
        for (int t = 0; t < 4; t++) begin
            chk("a_sel", sel[0], t);
            chk("a_busy", busy[0], 1);
            chk("a_ready_low", in_ready[0], 0);
            tick();
        end
        chk("a_ready_back", in_ready[0], 1);
        chk("a_sel_return", sel[0], 0);
        chk("a_busy_done", busy[0], 0);
        chk("a_err", err[0], 0);

        // HOLD=3, MSB-first, 0110
        send_word(1, 4'b0110);
        n = 0;
        while (busy[1] && n < 50) begin
            chk("b_sel", sel[1], 3 - n / 3);
            n++;
            tick();
        end
        chk("b_busy_cycles", n, 12);
        chk("b_sel_return", sel[1], 3);
        chk("b_err", err[1], 0);

        // Stuck-at-0 mux on 1111
        fault[0] = 1'b1;
        send_word(0, 4'b1111);
        chk("f_err_before_sample", err[0], 0);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("f_err_sticky", err[0], 1);
        end
        wait_idle(0);
        send_word(0, 4'b1111);
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        chk("f_set_wins", err[0], 1);
        wait_idle(0);
        tick();
        chk("f_err_held_idle", err[0], 1);
        fault[0]   = 1'b0;
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        chk("f_err_cleared", err[0], 0);

        // Back-pressure: 0001 held valid while 1000 is shifting
        send_word(0, 4'b1000);
        p = pulses[0];
        in_data[0]  = 4'b0001;
        in_valid[0] = 1'b1;
        n = 0;
        while (!in_ready[0] && n < 50) begin
            chk("bp_d_stable", d[0], 4'b1000);
            n++;
            tick();
        end
        chk("bp_wait_cycles", n, 4);
        tick();
        in_valid[0] = 1'b0;
        chk("bp_second_latched", d[0], 4'b0001);
        wait_idle(0);
        tick();
        tick();
        chk("bp_pulse_count", pulses[0] - p, 8);

        // Reset after the 2nd sample of 1010
        send_word(0, 4'b1010);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr_busy", busy[0], 0);
        chk("mr_sel", sel[0], 0);
        chk("mr_d", d[0], 0);
        chk("mr_valid", ser_valid[0], 0);
        chk("mr_ready", in_ready[0], 0);
        chk("mr_sel_b", sel[1], 3);
        rst_n = 1'b1;
        p = pulses[0];
        tick();
        chk("mr_ready_back", in_ready[0], 1);
        repeat (6) tick();
        chk("mr_no_pulses", pulses[0] - p, 0);

        // Random words on both instances concurrently
        fork
            rand_driver(0, 50);
            rand_driver(1, 50);
        join
        wait_idle(0);
        wait_idle(1);
        repeat (3) tick();
        chk("sb_empty0", sb[0].size(), 0);
        chk("sb_empty1", sb[1].size(), 0);
        chk("rand_err0", err[0], 0);
        chk("rand_err1", err[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
